dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage and a debug/loader port.
// CPU normally wins; a pending debug request is forced through after STARVE_MAX losses.
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic [31:0] dbg_rdata,
  output logic        dbg_rvalid,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_MemWrite,
  output logic        ram_MemRead,
  input  logic [31:0] ram_rdata,
  output logic        addr_err,
  output logic [1:0]  owner
);

  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] starve_q, starve_d;
  logic [31:0]     dbg_rdata_q, dbg_rdata_d;
  logic            dbg_rvalid_q, dbg_rvalid_d;
  logic            addr_err_q, addr_err_d;

  logic        dbg_own, cpu_own, any_own;
  logic        own_we, own_ok;
  logic [31:0] own_addr, own_wdata;
  logic        cpu_ok, dbg_ok;

  // Shift rather than slice so any DEPTH_LOG2 up to 32 stays legal.
  assign cpu_ok = (cpu_addr >> DEPTH_LOG2) == 32'd0;
  assign dbg_ok = (dbg_addr >> DEPTH_LOG2) == 32'd0;

  always_comb begin
    dbg_own   = rst_n && dbg_req && (!cpu_req || starve_q == StarveMax);
    cpu_own   = rst_n && cpu_req && !dbg_own;
    any_own   = dbg_own || cpu_own;
    own_we    = 1'b0;
    own_ok    = 1'b0;
    own_addr  = 32'd0;
    own_wdata = 32'd0;
    owner     = 2'b00;
    if (dbg_own) begin
      own_we    = dbg_we;
      own_ok    = dbg_ok;
      own_addr  = dbg_addr;
      own_wdata = dbg_wdata;
      owner     = 2'b10;
    end else if (cpu_own) begin
      own_we    = cpu_we;
      own_ok    = cpu_ok;
      own_addr  = cpu_addr;
      own_wdata = cpu_wdata;
      owner     = 2'b01;
    end

    ram_addr     = own_addr;
    ram_wdata    = own_wdata;
    ram_MemWrite = any_own && own_ok && own_we;
    ram_MemRead  = any_own && own_ok && !own_we;
    cpu_rdata    = (cpu_own && !cpu_we && cpu_ok) ? ram_rdata : 32'd0;
    cpu_stall    = dbg_own && cpu_req;
    dbg_gnt      = dbg_own;

    starve_d = starve_q;
    if (!dbg_req || dbg_own) begin
      starve_d = '0;
    end else if (cpu_own && starve_q != StarveMax) begin
      starve_d = starve_q + CntW'(1);
    end

    dbg_rvalid_d = dbg_own && !dbg_we;
    dbg_rdata_d  = dbg_rdata_q;
    if (dbg_rvalid_d) begin
      dbg_rdata_d = dbg_ok ? ram_rdata : 32'd0;
    end

    addr_err_d = addr_err_q || (any_own && !own_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q     <= '0;
      dbg_rdata_q  <= 32'd0;
      dbg_rvalid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset sequence, then random traffic
// checked against a behavioural model with its own copy of memory.
module tb_dmem_arbiter;
  localparam int unsigned SM = 4;
  localparam int unsigned DL = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        cpu_stall, dbg_gnt, dbg_rvalid, ram_MemWrite, ram_MemRead, addr_err;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_MAX(SM), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_MemWrite(ram_MemWrite),
    .ram_MemRead(ram_MemRead), .ram_rdata(ram_rdata), .addr_err(addr_err), .owner(owner)
  );

  // Memory attached to the DUT: combinational read, write on the clock edge.
  logic [31:0] mem [32];
  logic        preload;
  assign ram_rdata = mem[ram_addr[4:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 5) ? 32'd109 : (i == 7) ? 32'd5 : 32'h100 + i;
    end else if (ram_MemWrite) begin
      mem[ram_addr[4:0]] <= ram_wdata;
    end
  end

  int total = 0;
  int bad = 0;

  typedef struct {
    logic rst, creq, cwe;
    logic [31:0] caddr, cwd;
    logic dreq, dwe;
    logic [31:0] daddr, dwd;
    logic [1:0] own;
    logic stall, gnt;
    logic [31:0] crd;
    logic rv;
    logic [31:0] drd;
    logic aerr, mw, mr, regs;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] rst, cr, cw, ca, cd, dr, dw, da, dd,
                              ow, st, gn, crd, rv, drd, ae, mw, mr, rg);
    vec_t v;
    v.rst = rst[0]; v.creq = cr[0]; v.cwe = cw[0]; v.caddr = ca; v.cwd = cd;
    v.dreq = dr[0]; v.dwe = dw[0]; v.daddr = da; v.dwd = dd;
    v.own = ow[1:0]; v.stall = st[0]; v.gnt = gn[0]; v.crd = crd; v.rv = rv[0];
    v.drd = drd; v.aerr = ae[0]; v.mw = mw[0]; v.mr = mr[0]; v.regs = rg[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    dbg_req = v.dreq; dbg_we = v.dwe; dbg_addr = v.daddr; dbg_wdata = v.dwd;
  endtask

  task automatic check(input vec_t v, input string tag);
    chk({tag, " owner"}, 32'(owner), 32'(v.own));
    chk({tag, " cpu_stall"}, 32'(cpu_stall), 32'(v.stall));
    chk({tag, " dbg_gnt"}, 32'(dbg_gnt), 32'(v.gnt));
    chk({tag, " cpu_rdata"}, cpu_rdata, v.crd);
    chk({tag, " MemWrite"}, 32'(ram_MemWrite), 32'(v.mw));
    chk({tag, " MemRead"}, 32'(ram_MemRead), 32'(v.mr));
    if (v.regs) begin
      chk({tag, " dbg_rvalid"}, 32'(dbg_rvalid), 32'(v.rv));
      chk({tag, " dbg_rdata"}, dbg_rdata, v.drd);
      chk({tag, " addr_err"}, 32'(addr_err), 32'(v.aerr));
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    check(v, tag);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  // Reference model state
  logic [31:0] ref_mem [32];
  int          m_starve;
  logic        m_rv, m_aerr;
  logic [31:0] m_drd;

  function automatic logic [31:0] pick_addr();
    int r = $urandom_range(0, 24);
    if (r == 0) return 32 + $urandom_range(0, 31);
    if (r == 1) return $urandom | 32'h8000_0000;
    return $urandom_range(0, 31);
  endfunction

  initial begin
    vec_t v;
    logic pend, dw, cw, we, ok;
    logic [31:0] a, wd;

    preload = 1'b1;
    drive(mk(0, 1, 0, 5, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    preload = 1'b0;
    run_vec(mk(0, 1, 0, 5, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "reset");

    // Directed table
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 109, 0, 0, 0, 0, 1, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 1, 0, 5, 0, 1, 0, 7, 0, 1, 0, 0, 109, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 5, 0, 1, 0, 7, 0, 2, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 109, 1, 5, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 3, 32'hDEADBEEF, 2, 0, 1, 0, 0, 5, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 32'hDEADBEEF, 0, 5, 0, 0, 1, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 1, 1, 9, 32'h11, 1, 1, 9, 32'h22, 1, 0, 0, 0, 0, 5, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 9, 32'h11, 1, 1, 9, 32'h22, 2, 1, 1, 0, 0, 5, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 9, 0, 0, 0, 0, 0, 1, 0, 0, 32'h22, 0, 5, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 1, 32, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 40, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1));
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Debug read granted, then reset: pending rvalid dropped, sticky error cleared
    run_vec(mk(1, 0, 0, 0, 0, 1, 0, 5, 0, 2, 0, 1, 0, 0, 5, 1, 0, 1, 1), "rst_a");
    run_vec(mk(0, 1, 0, 5, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_b");
    run_vec(mk(0, 1, 0, 5, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "rst_c");
    run_vec(mk(1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 109, 0, 0, 0, 0, 1, 1), "rst_d");

    // Random traffic against the model
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];
    m_starve = 0; m_rv = 1'b0; m_drd = 32'd0; m_aerr = 1'b0; pend = 1'b0;
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 600; c++) begin
      v.rst = (c % 150) != 149;
      v.creq = $urandom_range(0, 2) != 0;
      v.cwe = 1'($urandom_range(0, 1));
      v.caddr = pick_addr();
      v.cwd = $urandom;
      if (!pend) begin
        v.dreq = $urandom_range(0, 2) == 0;
        v.dwe = 1'($urandom_range(0, 1));
        v.daddr = pick_addr();
        v.dwd = $urandom;
        pend = v.dreq;
      end
      dw = v.rst && v.dreq && (!v.creq || m_starve >= SM);
      cw = v.rst && v.creq && !dw;
      a  = dw ? v.daddr : cw ? v.caddr : 32'd0;
      wd = dw ? v.dwd : cw ? v.cwd : 32'd0;
      we = dw ? v.dwe : v.cwe;
      ok = a < 32;
      v.own = dw ? 2'd2 : cw ? 2'd1 : 2'd0;
      v.stall = dw && v.creq;
      v.gnt = dw;
      v.crd = (cw && !v.cwe && ok) ? ref_mem[a[4:0]] : 32'd0;
      v.mw = (dw || cw) && ok && we;
      v.mr = (dw || cw) && ok && !we;
      v.rv = m_rv; v.drd = m_drd; v.aerr = m_aerr; v.regs = 1'b1;
      drive(v);
      @(negedge clk);
      check(v, "rand");
      chk("rand ram_addr", ram_addr, a);
      chk("rand ram_wdata", ram_wdata, wd);
      @(posedge clk);
      if (!v.rst) begin
        m_starve = 0; m_rv = 1'b0; m_drd = 32'd0; m_aerr = 1'b0; pend = 1'b0;
      end else begin
        if (!v.dreq || dw) m_starve = 0;
        else if (cw) m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
        m_rv = dw && !v.dwe;
        if (m_rv) m_drd = ok ? ref_mem[a[4:0]] : 32'd0;
        if (v.mw) ref_mem[a[4:0]] = wd;
        if ((dw || cw) && !ok) m_aerr = 1'b1;
        if (dw) pend = 1'b0;
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
